mem_req_arb: RTL and testbench



---
 rtl/mem_req_arb_pkg.sv | 37 +++
 rtl/mem_req_arb_tag_fifo.sv | 56 +++++
 rtl/mem_req_arb.sv | 180 ++++++++++++++++++
 tb/tb_mem_req_arb.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_req_arb_pkg.sv
// Shared memory-interface codes for the request arbiter: command encodings,
// address/data widths, response tag values and the arbiter's internal enums.
package mem_codes;

    localparam int ADDR_W = 22;
    localparam int DATA_W = 64;

    // Commands written into the memory controller's request FIFO.
    typedef enum logic [1:0] {
        CMD_NOOP    = 2'd0,
        CMD_REFRESH = 2'd1,
        CMD_READ    = 2'd2,
        CMD_WRITE   = 2'd3
    } mem_cmd_e;

    // Destination of an outstanding read, stored in the in-order tag FIFO.
    typedef enum logic {
        TAG_MC   = 1'b0,
        TAG_DISP = 1'b1
    } tag_e;

    // Most recent winner of the fwd/mc round-robin pair.
    typedef enum logic {
        LAST_FWD = 1'b0,
        LAST_MC  = 1'b1
    } last_rw_e;

    // Which requester (if any) owns the request FIFO this cycle.
    typedef enum logic [2:0] {
        GNT_NONE,
        GNT_REFRESH,
        GNT_DISP,
        GNT_FWD,
        GNT_MC
    } grant_e;

endpackage

// File: rtl/mem_req_arb_tag_fifo.sv
// tag_fifo: 1-bit wide, DEPTH deep synchronous FIFO holding the destination
// of each outstanding read in issue order. DEPTH must be a power of two >= 2.
module tag_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   push_tag,
    input  logic                   pop,
    output logic                   head_tag,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DEPTH-1:0] tags;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign head_tag = tags[rd_ptr];

    // Pointer and occupancy bookkeeping; a simultaneous push and pop leaves count unchanged.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Tag storage, written at the tail on push.
    always_ff @(posedge clk) begin
        // NOTE: storage is deliberately not reset; only the pointers define valid entries.
        if (do_push) tags[wr_ptr] <= push_tag;
    end

endmodule

// File: rtl/mem_req_arb.sv
// mem_req_arb: merges framestore writes, motion-compensation reads, display
// reads and periodic refresh into the memory request FIFO, and routes read
// responses back to their issuing client using an in-order tag FIFO.
// Optional feature: define REFRESH_EN to build the refresh counter and give
// refresh top priority; without it CMD_REFRESH is never issued.
module mem_req_arb
    import mem_codes::*;
#(
    parameter int TAG_DEPTH      = 16,
    parameter int REFRESH_PERIOD = 1560
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fwd_valid,
    output logic              fwd_ready,
    input  logic [ADDR_W-1:0] fwd_addr,
    input  logic [DATA_W-1:0] fwd_dta,
    input  logic              mc_valid,
    output logic              mc_ready,
    input  logic [ADDR_W-1:0] mc_addr,
    input  logic              disp_valid,
    output logic              disp_ready,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic [1:0]        mem_req_wr_cmd,
    output logic [ADDR_W-1:0] mem_req_wr_addr,
    output logic [DATA_W-1:0] mem_req_wr_dta,
    output logic              mem_req_wr_en,
    input  logic              mem_req_wr_almost_full,
    input  logic [DATA_W-1:0] mem_res_rd_dta,
    output logic              mem_res_rd_en,
    input  logic              mem_res_rd_valid,
    output logic [DATA_W-1:0] mc_res_dta,
    output logic              mc_res_valid,
    input  logic              mc_res_almost_full,
    output logic [DATA_W-1:0] disp_res_dta,
    output logic              disp_res_valid,
    input  logic              disp_res_almost_full,
    output logic              tag_error
);

    grant_e                      grant;
    last_rw_e                    last_rw;
    logic                        refresh_pending;
    logic                        tag_push;
    logic                        tag_push_val;
    logic                        tag_head;
    logic [$clog2(TAG_DEPTH):0]  tag_count;
    logic                        tag_full;
    logic                        tag_empty;

`ifdef REFRESH_EN
    localparam int RC_W = (REFRESH_PERIOD > 1) ? $clog2(REFRESH_PERIOD) : 1;

    logic [RC_W-1:0] refresh_cnt;
    logic            refresh_wrap;

    assign refresh_wrap = (refresh_cnt == RC_W'(REFRESH_PERIOD - 1));

    // Free-running refresh timer; a wrap while a refresh is still pending is absorbed.
    always_ff @(posedge clk) begin
        if (!rst) begin
            refresh_cnt     <= '0;
            refresh_pending <= 1'b0;
        end else begin
            refresh_cnt     <= refresh_wrap ? '0 : refresh_cnt + RC_W'(1);
            refresh_pending <= refresh_wrap || (refresh_pending && (grant != GNT_REFRESH));
        end
    end
`else
    // The period only matters when the refresh timer is built in.
    logic unused_refresh_period;
    assign unused_refresh_period = (REFRESH_PERIOD > 0);
    assign refresh_pending       = 1'b0;
`endif

    // Pick at most one requester: refresh, then disp, then fwd/mc round-robin.
    always_comb begin
        // NOTE: default assigned first so no path through this block can infer a latch.
        grant = GNT_NONE;
        if (rst && !mem_req_wr_almost_full) begin
            if (refresh_pending)
                grant = GNT_REFRESH;
            else if (disp_valid && !tag_full)
                grant = GNT_DISP;
            else if (fwd_valid && mc_valid && !tag_full)
                grant = (last_rw == LAST_MC) ? GNT_FWD : GNT_MC;
            else if (fwd_valid)
                grant = GNT_FWD;
            else if (mc_valid && !tag_full)
                grant = GNT_MC;
        end
    end

    assign fwd_ready    = (grant == GNT_FWD);
    assign mc_ready     = (grant == GNT_MC);
    assign disp_ready   = (grant == GNT_DISP);
    assign tag_push     = (grant == GNT_MC) || (grant == GNT_DISP);
    assign tag_push_val = (grant == GNT_DISP) ? TAG_DISP : TAG_MC;

    // Register the granted request toward the request FIFO and track the round-robin winner.
    always_ff @(posedge clk) begin
        if (!rst) begin
            mem_req_wr_cmd  <= CMD_NOOP;
            mem_req_wr_addr <= '0;
            mem_req_wr_dta  <= '0;
            mem_req_wr_en   <= 1'b0;
            last_rw         <= LAST_MC;
        end else begin
            mem_req_wr_en <= (grant != GNT_NONE);
            case (grant)
                GNT_REFRESH: begin
                    mem_req_wr_cmd  <= CMD_REFRESH;
                    mem_req_wr_addr <= '0;
                    mem_req_wr_dta  <= '0;
                end
                GNT_DISP: begin
                    mem_req_wr_cmd  <= CMD_READ;
                    mem_req_wr_addr <= disp_addr;
                    mem_req_wr_dta  <= '0;
                end
                GNT_FWD: begin
                    mem_req_wr_cmd  <= CMD_WRITE;
                    mem_req_wr_addr <= fwd_addr;
                    mem_req_wr_dta  <= fwd_dta;
                    last_rw         <= LAST_FWD;
                end
                GNT_MC: begin
                    mem_req_wr_cmd  <= CMD_READ;
                    mem_req_wr_addr <= mc_addr;
                    mem_req_wr_dta  <= '0;
                    last_rw         <= LAST_MC;
                end
                default: ;
            endcase
        end
    end

    tag_fifo #(
        .DEPTH    (TAG_DEPTH)
    ) u_tag_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (tag_push),
        .push_tag (tag_push_val),
        .pop      (mem_res_rd_valid),
        .head_tag (tag_head),
        .count    (tag_count),
        .full     (tag_full),
        .empty    (tag_empty)
    );

    // Pull responses while reads are outstanding and route each to its head-tag client.
    always_ff @(posedge clk) begin
        if (!rst) begin
            mem_res_rd_en  <= 1'b0;
            mc_res_valid   <= 1'b0;
            mc_res_dta     <= '0;
            disp_res_valid <= 1'b0;
            disp_res_dta   <= '0;
            tag_error      <= 1'b0;
        end else begin
            mem_res_rd_en  <= (tag_count != '0) &&
                              !((tag_head == TAG_DISP) ? disp_res_almost_full : mc_res_almost_full);
            mc_res_valid   <= 1'b0;
            disp_res_valid <= 1'b0;
            if (mem_res_rd_valid) begin
                if (tag_empty) begin
                    tag_error <= 1'b1;
                end else if (tag_head == TAG_DISP) begin
                    disp_res_valid <= 1'b1;
                    disp_res_dta   <= mem_res_rd_dta;
                end else begin
                    mc_res_valid <= 1'b1;
                    mc_res_dta   <= mem_res_rd_dta;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_req_arb.sv
// Testbench for mem_req_arb: table-driven grant vectors, a request scoreboard,
// a response-FIFO model with a tag scoreboard, and a second instance with a
// short refresh period to observe refresh timing (or its absence).
module tb_mem_req_arb;
    import mem_codes::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst = 1'b0;
    logic              fwd_valid = 1'b0, mc_valid = 1'b0, disp_valid = 1'b0;
    logic              fwd_ready, mc_ready, disp_ready;
    logic [ADDR_W-1:0] fwd_addr = '0, mc_addr = '0, disp_addr = '0;
    logic [DATA_W-1:0] fwd_dta = '0;
    logic [1:0]        mem_req_wr_cmd;
    logic [ADDR_W-1:0] mem_req_wr_addr;
    logic [DATA_W-1:0] mem_req_wr_dta;
    logic              mem_req_wr_en;
    logic              mem_req_wr_almost_full = 1'b0;
    logic [DATA_W-1:0] mem_res_rd_dta = '0;
    logic              mem_res_rd_en;
    logic              mem_res_rd_valid = 1'b0;
    logic [DATA_W-1:0] mc_res_dta, disp_res_dta;
    logic              mc_res_valid, disp_res_valid;
    logic              mc_res_almost_full = 1'b0, disp_res_almost_full = 1'b0;
    logic              tag_error;

    // Outputs of the short-period refresh instance (all clients idle).
    logic              r_fwd_ready, r_mc_ready, r_disp_ready;
    logic [1:0]        r_cmd;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_dta;
    logic              r_wr_en, r_rd_en;
    logic [DATA_W-1:0] r_mc_res_dta, r_disp_res_dta;
    logic              r_mc_res_valid, r_disp_res_valid, r_tag_error;

    mem_req_arb #(.TAG_DEPTH(16), .REFRESH_PERIOD(1560)) dut (
        .clk(clk), .rst(rst),
        .fwd_valid(fwd_valid), .fwd_ready(fwd_ready), .fwd_addr(fwd_addr), .fwd_dta(fwd_dta),
        .mc_valid(mc_valid), .mc_ready(mc_ready), .mc_addr(mc_addr),
        .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_addr(disp_addr),
        .mem_req_wr_cmd(mem_req_wr_cmd), .mem_req_wr_addr(mem_req_wr_addr),
        .mem_req_wr_dta(mem_req_wr_dta), .mem_req_wr_en(mem_req_wr_en),
        .mem_req_wr_almost_full(mem_req_wr_almost_full),
        .mem_res_rd_dta(mem_res_rd_dta), .mem_res_rd_en(mem_res_rd_en),
        .mem_res_rd_valid(mem_res_rd_valid),
        .mc_res_dta(mc_res_dta), .mc_res_valid(mc_res_valid), .mc_res_almost_full(mc_res_almost_full),
        .disp_res_dta(disp_res_dta), .disp_res_valid(disp_res_valid),
        .disp_res_almost_full(disp_res_almost_full),
        .tag_error(tag_error)
    );

    mem_req_arb #(.TAG_DEPTH(16), .REFRESH_PERIOD(8)) dut_r (
        .clk(clk), .rst(rst),
        .fwd_valid(1'b0), .fwd_ready(r_fwd_ready), .fwd_addr('0), .fwd_dta('0),
        .mc_valid(1'b0), .mc_ready(r_mc_ready), .mc_addr('0),
        .disp_valid(1'b0), .disp_ready(r_disp_ready), .disp_addr('0),
        .mem_req_wr_cmd(r_cmd), .mem_req_wr_addr(r_addr),
        .mem_req_wr_dta(r_dta), .mem_req_wr_en(r_wr_en),
        .mem_req_wr_almost_full(1'b0),
        .mem_res_rd_dta('0), .mem_res_rd_en(r_rd_en), .mem_res_rd_valid(1'b0),
        .mc_res_dta(r_mc_res_dta), .mc_res_valid(r_mc_res_valid), .mc_res_almost_full(1'b0),
        .disp_res_dta(r_disp_res_dta), .disp_res_valid(r_disp_res_valid), .disp_res_almost_full(1'b0),
        .tag_error(r_tag_error)
    );

    typedef struct {
        logic [1:0]        cmd;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] dta;
    } req_t;

    typedef struct {
        logic       fv, mv, dv, af;
        logic [2:0] rdy;  // {fwd, mc, disp}
    } vec_t;

    localparam logic [2:0] R_F = 3'b100, R_M = 3'b010, R_D = 3'b001, R_0 = 3'b000;

    int                n_checks = 0;
    int                n_fail   = 0;
    req_t              wr_q[$];
    logic              tag_q[$];
    logic [DATA_W-1:0] mem_q[$];
    logic              exp_res_pend = 1'b0;
    logic              exp_res_dest = 1'b0;
    logic [DATA_W-1:0] exp_res_dta  = '0;
    logic              last_rd_en   = 1'b0;
    logic              inject_stray = 1'b0;
    int                r_idx        = 0;
    vec_t              vt[22];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Per-cycle scoreboard compare plus response FIFO model; runs #1 after each edge.
    task automatic monitor();
        logic r_exp;
        check("wr_en", mem_req_wr_en, wr_q.size() != 0);
        if (wr_q.size() != 0) begin
            req_t e = wr_q.pop_front();
            if (mem_req_wr_en) begin
                check("wr_cmd", mem_req_wr_cmd, e.cmd);
                check("wr_addr", mem_req_wr_addr, e.addr);
                check("wr_dta", mem_req_wr_dta, e.dta);
            end
        end
        check("mc_res_valid", mc_res_valid, exp_res_pend && (exp_res_dest == TAG_MC));
        check("disp_res_valid", disp_res_valid, exp_res_pend && (exp_res_dest == TAG_DISP));
        if (exp_res_pend)
            check("res_dta", (exp_res_dest == TAG_DISP) ? disp_res_dta : mc_res_dta, exp_res_dta);
        exp_res_pend     = 1'b0;
        mem_res_rd_valid = 1'b0;
        mem_res_rd_dta   = '0;
        if (inject_stray) begin
            mem_res_rd_valid = 1'b1;
            mem_res_rd_dta   = 64'hBAD0_BAD0_BAD0_BAD0;
            inject_stray     = 1'b0;
        end else if (last_rd_en && mem_q.size() != 0) begin
            mem_res_rd_valid = 1'b1;
            mem_res_rd_dta   = mem_q.pop_front();
            if (tag_q.size() != 0) begin
                exp_res_pend = 1'b1;
                exp_res_dest = tag_q.pop_front();
                exp_res_dta  = mem_res_rd_dta;
            end
        end
        last_rd_en = mem_res_rd_en;
        // Refresh instance: counter 0 right after reset, first refresh on the bus 9 cycles later.
        r_idx = rst ? r_idx + 1 : 0;
`ifdef REFRESH_EN
        r_exp = rst && (r_idx >= 9) && ((r_idx - 9) % 8 == 0);
`else
        r_exp = 1'b0;
`endif
        check("refresh wr_en", r_wr_en, r_exp);
        if (r_exp) begin
            check("refresh cmd", r_cmd, CMD_REFRESH);
            check("refresh addr", r_addr, '0);
            check("refresh dta", r_dta, '0);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        monitor();
    endtask

    // Drive one cycle of requests, check readies, and record what the DUT owes us.
    task automatic drive(input logic fv, input logic mv, input logic dv, input logic af,
                         input logic [2:0] exp_rdy, input string name);
        fwd_valid = fv; mc_valid = mv; disp_valid = dv; mem_req_wr_almost_full = af;
        fwd_addr  = ADDR_W'($urandom);
        fwd_dta   = {$urandom, $urandom};
        mc_addr   = ADDR_W'($urandom);
        disp_addr = ADDR_W'($urandom);
        #1;
        check({name, ".ready"}, {fwd_ready, mc_ready, disp_ready}, exp_rdy);
        if (exp_rdy == R_F) begin
            wr_q.push_back('{CMD_WRITE, fwd_addr, fwd_dta});
        end else if (exp_rdy == R_M) begin
            wr_q.push_back('{CMD_READ, mc_addr, 64'd0});
            tag_q.push_back(TAG_MC);
        end else if (exp_rdy == R_D) begin
            wr_q.push_back('{CMD_READ, disp_addr, 64'd0});
            tag_q.push_back(TAG_DISP);
        end
        tick();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, R_0, "idle");
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b0;
        fwd_valid = 1'b0; mc_valid = 1'b0; disp_valid = 1'b0;
        mem_res_rd_valid = 1'b0; inject_stray = 1'b0;
        wr_q.delete(); tag_q.delete(); mem_q.delete();
        exp_res_pend = 1'b0; last_rd_en = 1'b0;
        repeat (cycles) tick();
        rst = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached without summary (actual=timeout required=finish)");
        $fatal(1);
    end

    initial begin
        vt[0]  = '{1, 1, 0, 0, R_F};  vt[1]  = '{1, 1, 0, 0, R_M};
        vt[2]  = '{1, 1, 0, 0, R_F};  vt[3]  = '{1, 1, 0, 0, R_M};
        vt[4]  = '{1, 0, 0, 0, R_F};  vt[5]  = '{1, 1, 0, 0, R_M};
        vt[6]  = '{0, 1, 0, 0, R_M};  vt[7]  = '{1, 1, 0, 0, R_F};
        vt[8]  = '{1, 1, 1, 0, R_D};  vt[9]  = '{1, 1, 1, 0, R_D};
        vt[10] = '{1, 1, 1, 0, R_D};  vt[11] = '{1, 1, 1, 1, R_0};
        vt[12] = '{1, 1, 1, 1, R_0};  vt[13] = '{1, 1, 1, 1, R_0};
        vt[14] = '{1, 1, 1, 1, R_0};  vt[15] = '{1, 1, 1, 1, R_0};
        vt[16] = '{1, 1, 1, 0, R_D};  vt[17] = '{1, 1, 0, 0, R_M};
        vt[18] = '{0, 0, 0, 0, R_0};  vt[19] = '{0, 0, 1, 0, R_D};
        vt[20] = '{1, 0, 0, 1, R_0};  vt[21] = '{1, 0, 0, 0, R_F};

        // Reset state, with every client requesting.
        rst = 1'b0;
        fwd_valid = 1'b1; mc_valid = 1'b1; disp_valid = 1'b1;
        tick(); tick();
        check("reset ready", {fwd_ready, mc_ready, disp_ready}, R_0);
        check("reset rd_en", mem_res_rd_en, 1'b0);
        check("reset tag_error", tag_error, 1'b0);
        check("reset cmd", mem_req_wr_cmd, CMD_NOOP);
        check("reset addr", mem_req_wr_addr, '0);
        check("reset dta", mem_req_wr_dta, '0);
        fwd_valid = 1'b0; mc_valid = 1'b0; disp_valid = 1'b0;
        rst = 1'b1;

        // Arbitration vectors: round-robin, disp priority, almost-full stall.
        for (int i = 0; i < 22; i++)
            drive(vt[i].fv, vt[i].mv, vt[i].dv, vt[i].af, vt[i].rdy, $sformatf("vec%0d", i));
        idle(2);
        check("reads outstanding rd_en", mem_res_rd_en, 1'b1);

        // Mid-operation reset drops outstanding tags.
        do_reset(1);
        idle(3);
        check("post-reset rd_en", mem_res_rd_en, 1'b0);

        // Response routing: mc, disp, mc reads; mc buffer full holds back rd_en first.
        mc_res_almost_full = 1'b1;
        drive(0, 1, 0, 0, R_M, "route mc0");
        drive(0, 0, 1, 0, R_D, "route disp");
        drive(0, 1, 0, 0, R_M, "route mc1");
        idle(2);
        check("mc almost full rd_en", mem_res_rd_en, 1'b0);
        mc_res_almost_full = 1'b0;
        mem_q.push_back(64'hAAAA_0000_0000_000A);
        mem_q.push_back(64'hBBBB_0000_0000_000B);
        mem_q.push_back(64'hCCCC_0000_0000_000C);
        idle(8);
        check("route drained", mem_q.size(), 0);
        check("route rd_en idle", mem_res_rd_en, 1'b0);

        // Fill the tag FIFO; the 17th read stalls while a write still goes through.
        do_reset(1);
        for (int i = 0; i < 16; i++) drive(0, 1, 0, 0, R_M, $sformatf("fill%0d", i));
        drive(0, 1, 0, 0, R_0, "tag full mc");
        drive(0, 0, 1, 0, R_0, "tag full disp");
        drive(1, 0, 0, 0, R_F, "tag full fwd");
        for (int i = 0; i < 16; i++) mem_q.push_back(64'h1000 + 64'(i));
        idle(20);
        check("full drained", mem_q.size(), 0);

        // Reads granted while responses are popping.
        drive(0, 1, 0, 0, R_M, "overlap r0");
        drive(0, 1, 0, 0, R_M, "overlap r1");
        mem_q.push_back(64'h2000); mem_q.push_back(64'h2001);
        for (int i = 0; i < 4; i++) drive(0, 1, 0, 0, R_M, $sformatf("overlap r%0d", i + 2));
        for (int i = 0; i < 4; i++) mem_q.push_back(64'h2002 + 64'(i));
        idle(10);
        check("overlap drained", mem_q.size(), 0);
        check("overlap rd_en idle", mem_res_rd_en, 1'b0);

        // Stray response with no outstanding tag.
        check("tag_error before", tag_error, 1'b0);
        inject_stray = 1'b1;
        idle(2);
        check("tag_error set", tag_error, 1'b1);
        idle(3);
        check("tag_error sticky", tag_error, 1'b1);
        do_reset(1);
        check("tag_error reset", tag_error, 1'b0);
        idle(12);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
